// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage
package ifetch_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} fetch_state_t;
    localparam int DEPTH_DEFAULT = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/ifetch_32_if.sv
// ifetch_32_if: instruction-memory and decode-side handshakes of the fetch stage
interface ifetch_32_if #(parameter int AW = 32);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic [31:0]   instruction;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          dec_ready;
    modport master (
        output imem_req, imem_addr, instruction, instr_pc, instr_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
    );
    modport slave (
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
        output imem_gnt, imem_rvalid, imem_rdata, dec_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: small FIFO of {pc, instruction} entries with synchronous clear
module ifetch_queue #(
    parameter int DEPTH = 2,
    parameter int W = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: the head is masked by the caller while empty
    always_ff @(posedge clk)
        if (push && !clear) mem[wptr] <= din;
    assign head = mem[rptr];
endmodule

// File: rtl/ifetch_32.sv
// ifetch_32: one-outstanding-read instruction fetch with flush and a decode queue
module ifetch_32
    import ifetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          flush,
    output logic          pc_advance,
    ifetch_32_if.master   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t  state, state_nx;
    logic [AW-1:0] req_pc;
    logic [CW-1:0] count;
    logic [AW+31:0] head;
    logic room, gnt, push, pop;
    // the outstanding read counts against queue space so a push never overflows
    assign room = (count + CW'(state == S_WAIT)) < CW'(DEPTH);
    assign bus.imem_req = reset && state == S_IDLE && room && !flush;
    assign bus.imem_addr = addr;
    assign gnt = bus.imem_req && bus.imem_gnt;
    assign pc_advance = gnt;
    assign push = state == S_WAIT && bus.imem_rvalid && !flush;
    assign pop = bus.instr_valid && bus.dec_ready;
    assign bus.instr_valid = count != '0;
    assign bus.instruction = bus.instr_valid ? head[31:0] : NOP_INSTR;
    assign bus.instr_pc = bus.instr_valid ? head[AW+31:32] : '0;
    always_comb
        state_nx = state == S_IDLE ? (gnt ? S_WAIT : S_IDLE) :
                   bus.imem_rvalid ? S_IDLE :
                   (state == S_WAIT && !flush) ? S_WAIT : S_DROP;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nx;
            if (gnt) req_pc <= addr;
        end
    end
    ifetch_queue #(.DEPTH(DEPTH), .W(AW + 32)) u_queue (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   ({req_pc, bus.imem_rdata}),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_ifetch_32.sv
// tb_ifetch_32: directed self-checking bench for the fetch stage
module tb_ifetch_32;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        pc_advance;
    int checks = 0;
    int errors = 0;
    ifetch_32_if #(.AW(32)) bus ();
    ifetch_32 #(.DEPTH(2), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .flush      (flush),
        .pc_advance (pc_advance),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    initial begin
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.dec_ready = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus.instruction), 64'h0);
        chk("rst_pc", 64'(bus.instr_pc), 64'h0);
        chk("rst_adv", 64'(pc_advance), 64'd0);
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        // release away from the clock edge; first fetch at 0
        @(negedge clk);
        reset = 1'b1;
        settle();
        chk("t1_req", 64'(bus.imem_req), 64'd1);
        chk("t1_adv", 64'(pc_advance), 64'd1);
        chk("t1_iaddr", 64'(bus.imem_addr), 64'h0);
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h2002_0005;
        addr = 32'h4;
        settle();
        chk("t1_wait_req", 64'(bus.imem_req), 64'd0);
        chk("t1_wait_valid", 64'(bus.instr_valid), 64'd0);
        chk("t1_wait_adv", 64'(pc_advance), 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("t1_valid", 64'(bus.instr_valid), 64'd1);
        chk("t1_instr", 64'(bus.instruction), 64'h2002_0005);
        chk("t1_pc", 64'(bus.instr_pc), 64'h0);
        chk("t1_req_again", 64'(bus.imem_req), 64'd1);
        // second fetch fills the queue
        bus.imem_gnt = 1'b1;
        settle();
        chk("t2_adv4", 64'(pc_advance), 64'd1);
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_00A4;
        addr = 32'h8;
        settle();
        chk("t2_req_wait", 64'(bus.imem_req), 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt = 1'b1;
        settle();
        chk("t2_full_req", 64'(bus.imem_req), 64'd0);
        chk("t2_full_adv", 64'(pc_advance), 64'd0);
        chk("t2_head_instr", 64'(bus.instruction), 64'h2002_0005);
        tick();
        settle();
        chk("t2_hold_instr", 64'(bus.instruction), 64'h2002_0005);
        chk("t2_hold_pc", 64'(bus.instr_pc), 64'h0);
        chk("t2_hold_req", 64'(bus.imem_req), 64'd0);
        bus.imem_gnt = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        settle();
        chk("t2_pop1_valid", 64'(bus.instr_valid), 64'd1);
        chk("t2_pop1_instr", 64'(bus.instruction), 64'hA4);
        chk("t2_pop1_pc", 64'(bus.instr_pc), 64'h4);
        tick();
        bus.dec_ready = 1'b0;
        settle();
        chk("t2_empty_valid", 64'(bus.instr_valid), 64'd0);
        chk("t2_empty_instr", 64'(bus.instruction), 64'h0);
        // flush while waiting; late response must be dropped
        bus.imem_gnt = 1'b1;
        settle();
        chk("t3_adv8", 64'(pc_advance), 64'd1);
        tick();
        bus.imem_gnt = 1'b0;
        flush = 1'b1;
        addr = 32'h1000;
        settle();
        chk("t3_flush_req", 64'(bus.imem_req), 64'd0);
        chk("t3_flush_adv", 64'(pc_advance), 64'd0);
        tick();
        flush = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_gnt = 1'b1;
        settle();
        chk("t3_drop_req", 64'(bus.imem_req), 64'd0);
        chk("t3_drop_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("t3_after_valid", 64'(bus.instr_valid), 64'd0);
        chk("t3_after_instr", 64'(bus.instruction), 64'h0);
        chk("t3_new_req", 64'(bus.imem_req), 64'd1);
        chk("t3_new_addr", 64'(bus.imem_addr), 64'h1000);
        chk("t3_new_adv", 64'(pc_advance), 64'd1);
        tick();
        // flush coincident with the response: straight back to idle
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        flush = 1'b1;
        addr = 32'h2000;
        tick();
        bus.imem_rvalid = 1'b0;
        flush = 1'b0;
        settle();
        chk("t4_idle_req", 64'(bus.imem_req), 64'd1);
        chk("t4_valid", 64'(bus.instr_valid), 64'd0);
        // grant withheld for five cycles
        for (int i = 0; i < 5; i++) begin
            chk("t5_req", 64'(bus.imem_req), 64'd1);
            chk("t5_addr", 64'(bus.imem_addr), 64'h2000);
            chk("t5_adv", 64'(pc_advance), 64'd0);
            tick();
        end
        bus.imem_gnt = 1'b1;
        settle();
        chk("t5_grant_adv", 64'(pc_advance), 64'd1);
        tick();
        // reset mid-fetch, then a stray response
        bus.imem_gnt = 1'b0;
        reset = 1'b0;
        settle();
        chk("t6_rst_req", 64'(bus.imem_req), 64'd0);
        chk("t6_rst_adv", 64'(pc_advance), 64'd0);
        chk("t6_rst_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0BAD_0BAD;
        settle();
        chk("t6_idle_req", 64'(bus.imem_req), 64'd1);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        chk("t6_stray_valid", 64'(bus.instr_valid), 64'd0);
        chk("t6_stray_instr", 64'(bus.instruction), 64'h0);
        chk("t6_stray_pc", 64'(bus.instr_pc), 64'h0);
        chk("t6_stray_req", 64'(bus.imem_req), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
